window_scan_ctrl: RTL

//  Sequencer for the 11x11 median-filter window datapath. It takes a raster disparity stream, drives the

---
 rtl/median_pkg.sv | 9 +
 rtl/scan_counter.sv | 44 ++++
 rtl/window_scan_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/median_pkg.sv
// Shared definitions for the 11x11 median-filter window path: window geometry,
// pad pixel value and the scan sequencer state encoding.
package median_pkg;
  localparam int K = 11;
  localparam int R = (K - 1) / 2;
  localparam logic [8:0] PAD_PIX = 9'h100;

  typedef enum logic [2:0] {IDLE, RUN, FLUSH_COL, FLUSH_ROW, DONE} scan_state_t;
endpackage

// File: rtl/scan_counter.sv
// Raster col/row counters over the padded frame (IMG_W+R) x (IMG_H+R); they move
// only on a step and return to (0,0) after the final step of a frame.
module scan_counter #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int R     = 5,
  parameter int CW    = 10,
  parameter int RW    = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          step,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          col_in,
  output logic          col_last_px,
  output logic          col_wrap,
  output logic          row_next_in,
  output logic          frame_last
);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W + R - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H + R - 1);

  assign col_in      = col < CW'(IMG_W);
  assign col_last_px = col == CW'(IMG_W - 1);
  assign col_wrap    = col == COL_LAST;
  // row+1 still inside the image, written without the +1 to avoid overflow at ROW_LAST
  assign row_next_in = row < RW'(IMG_H - 1);
  assign frame_last  = col_wrap && (row == ROW_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (step) begin
      if (col_wrap) begin
        col <= '0;
        row <= frame_last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end
endmodule

// File: rtl/window_scan_ctrl.sv
// Window scan sequencer: consumes the raster disparity stream, drives line-buffer
// writes and window shifts, inserts right/bottom flush steps and tags valid windows.
module window_scan_ctrl
  import median_pkg::scan_state_t, median_pkg::IDLE, median_pkg::RUN,
         median_pkg::FLUSH_COL, median_pkg::FLUSH_ROW, median_pkg::DONE;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int K     = median_pkg::K,
  parameter int CW    = 10,
  parameter int RW    = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          dn_ready,
  output logic [CW-1:0] lb_addr,
  output logic          lb_we,
  output logic          pad_sel,
  output logic          win_clken,
  output logic [K-1:0]  row_mask,
  output logic [K-1:0]  col_mask,
  output logic          out_valid,
  output logic [CW-1:0] out_x,
  output logic [RW-1:0] out_y,
  output logic          busy,
  output logic          frame_done
);
  localparam int R = (K - 1) / 2;

  scan_state_t   state;
  logic          step;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          col_in, col_last_px, col_wrap, row_next_in, frame_last;
  logic [K-1:0]  rm_next;

  scan_counter #(.IMG_W(IMG_W), .IMG_H(IMG_H), .R(R), .CW(CW), .RW(RW)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .step       (step),
    .col        (col),
    .row        (row),
    .col_in     (col_in),
    .col_last_px(col_last_px),
    .col_wrap   (col_wrap),
    .row_next_in(row_next_in),
    .frame_last (frame_last)
  );

  // Step qualification and pixel handshake per scan region
  always_comb begin
    step     = 1'b0;
    in_ready = 1'b0;
    lb_we    = 1'b0;
    pad_sel  = 1'b0;
    case (state)
      RUN: begin
        step     = in_valid & dn_ready;
        in_ready = dn_ready;
        lb_we    = step;
      end
      FLUSH_COL: begin
        step    = dn_ready;
        pad_sel = 1'b1;
      end
      FLUSH_ROW: begin
        step    = dn_ready;
        lb_we   = step;
        pad_sel = 1'b1;
      end
      default: ;
    endcase
  end

  // Line k of the window holds image row (row-k); valid when that lands inside the frame
  always_comb begin
    rm_next = '0;
    for (int k = 0; k < K; k++)
      rm_next[k] = (int'(row) >= k) && (int'(row) < IMG_H + k);
  end

  assign win_clken  = step;
  assign lb_addr    = col_in ? col : '0;
  assign busy       = state != IDLE;
  assign frame_done = state == DONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      row_mask  <= '0;
      col_mask  <= '0;
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: if (start) state <= RUN;
        DONE: state <= IDLE;
        default: if (step) begin
          if (frame_last)       state <= DONE;
          else if (col_wrap)    state <= row_next_in ? RUN : FLUSH_ROW;
          else if (col_last_px) state <= FLUSH_COL;
        end
      endcase
      if (step) begin
        col_mask <= col_wrap ? '0 : {col_mask[K-2:0], col_in};
        row_mask <= rm_next;
        if (row >= RW'(R) && col >= CW'(R)) begin
          out_valid <= 1'b1;
          out_x     <= col - CW'(R);
          out_y     <= row - RW'(R);
        end
      end
    end
  end
endmodule
